// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use stalls, taken-branch flushes,
// data-memory freezes with timeout abort/halt, and stall/flush performance counters.
module hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IF_ID_rs,
    input  logic [4:0]       IF_ID_rt,
    input  logic             ID_uses_rt,
    input  logic [4:0]       ID_EX_rt,
    input  logic             ID_EX_memread,
    input  logic             EX_MEM_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             err_clr,
    input  logic             cnt_clr,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             EX_MEM_flush,
    output logic             pipe_freeze,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state_o
);

    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_MEM_WAIT = 2'b01;
    localparam logic [1:0] ST_ABORT    = 2'b10;
    localparam logic [1:0] ST_HALT     = 2'b11;

    localparam int                WAIT_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO  = WAIT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = CNT_W'(0);

    // A load in EX whose destination feeds a source of the instruction in ID; r0 never hazards.
    function automatic logic load_use(input logic       memread,
                                      input logic [4:0] ex_rt,
                                      input logic [4:0] id_rs,
                                      input logic [4:0] id_rt,
                                      input logic       uses_rt);
        load_use = memread & (ex_rt != 5'd0) &
                   ((ex_rt == id_rs) | (uses_rt & (ex_rt == id_rt)));
    endfunction

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;

    logic busy_s, lu_s;
    logic pc_we_s, ifid_we_s, ifid_fl_s, idex_fl_s, exmem_fl_s, freeze_s;
    logic br_applied_s, stall_inc_s;

    // Hazard qualifiers from the current pipeline contents.
    always_comb begin
        busy_s = dmem_req & ~dmem_ready;
        lu_s   = load_use(ID_EX_memread, ID_EX_rt, IF_ID_rs, IF_ID_rt, ID_uses_rt);
    end

    // Mealy control decode and next-state selection.
    always_comb begin
        pc_we_s      = 1'b1;
        ifid_we_s    = 1'b1;
        ifid_fl_s    = 1'b0;
        idex_fl_s    = 1'b0;
        exmem_fl_s   = 1'b0;
        freeze_s     = 1'b0;
        br_applied_s = 1'b0;
        state_d      = state_q;
        wait_d       = wait_q;
        err_d        = err_q;
        case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                if (busy_s) begin
                    freeze_s  = 1'b1;
                    pc_we_s   = 1'b0;
                    ifid_we_s = 1'b0;
                    if (state_q == ST_RUN) begin
                        state_d = ST_MEM_WAIT;
                        wait_d  = WAIT_ONE;
                    end else if (wait_q == WAIT_LAST) begin
                        state_d = ST_ABORT;
                        wait_d  = WAIT_ZERO;
                    end else begin
                        wait_d  = wait_q + WAIT_ONE;
                    end
                end else begin
                    // Release cycle behaves like RUN, so a branch held during the freeze lands here.
                    state_d = ST_RUN;
                    wait_d  = WAIT_ZERO;
                    if (EX_MEM_branch_taken) begin
                        ifid_fl_s    = 1'b1;
                        idex_fl_s    = 1'b1;
                        exmem_fl_s   = 1'b1;
                        br_applied_s = 1'b1;
                    end else if (lu_s) begin
                        pc_we_s   = 1'b0;
                        ifid_we_s = 1'b0;
                        idex_fl_s = 1'b1;
                    end else begin
                        pc_we_s   = 1'b1;
                    end
                end
            end
            ST_ABORT: begin
                pc_we_s    = 1'b0;
                ifid_we_s  = 1'b0;
                ifid_fl_s  = 1'b1;
                idex_fl_s  = 1'b1;
                exmem_fl_s = 1'b1;
                err_d      = 1'b1;
                state_d    = ST_HALT;
                wait_d     = WAIT_ZERO;
            end
            ST_HALT: begin
                pc_we_s   = 1'b0;
                ifid_we_s = 1'b0;
                freeze_s  = 1'b1;
                if (err_clr) begin
                    state_d = ST_RUN;
                    err_d   = 1'b0;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                pc_we_s   = 1'b0;
                ifid_we_s = 1'b0;
                state_d   = ST_RUN;
                wait_d    = WAIT_ZERO;
            end
        endcase
    end

    // Performance counter next values; a clear beats a same-cycle increment.
    always_comb begin
        stall_inc_s = ~pc_we_s & (state_q != ST_HALT);
        if (cnt_clr) begin
            stall_d = CNT_ZERO;
            flush_d = CNT_ZERO;
        end else begin
            stall_d = stall_inc_s  ? (stall_q + CNT_ONE) : stall_q;
            flush_d = br_applied_s ? (flush_q + CNT_ONE) : flush_q;
        end
    end

    // State, wait timer, sticky error and counters.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_RUN;
            wait_q  <= WAIT_ZERO;
            err_q   <= 1'b0;
            stall_q <= CNT_ZERO;
            flush_q <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    // While reset is held the pipe is kept flushed and the PC parked.
    always_comb begin
        PC_write     = rst_i & pc_we_s;
        IF_ID_write  = rst_i & ifid_we_s;
        IF_ID_flush  = ~rst_i | ifid_fl_s;
        ID_EX_flush  = ~rst_i | idex_fl_s;
        EX_MEM_flush = ~rst_i | exmem_fl_s;
        pipe_freeze  = rst_i & freeze_s;
        mem_err      = err_q;
        stall_cnt    = stall_q;
        flush_cnt    = flush_q;
        state_o      = state_q;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized scoreboard bench for hazard_ctrl against a behavioural reference model.
module tb_hazard_ctrl;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 4;
    localparam int CMOD    = 1 << CNT_W;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic [4:0] IF_ID_rs = 5'd0, IF_ID_rt = 5'd0, ID_EX_rt = 5'd0;
    logic ID_uses_rt = 1'b0, ID_EX_memread = 1'b0, EX_MEM_branch_taken = 1'b0;
    logic dmem_req = 1'b0, dmem_ready = 1'b0, err_clr = 1'b0, cnt_clr = 1'b0;
    logic PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_flush, pipe_freeze, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [1:0] state_o;

    hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .ID_uses_rt(ID_uses_rt),
        .ID_EX_rt(ID_EX_rt), .ID_EX_memread(ID_EX_memread),
        .EX_MEM_branch_taken(EX_MEM_branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .err_clr(err_clr), .cnt_clr(cnt_clr),
        .PC_write(PC_write), .IF_ID_write(IF_ID_write),
        .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .EX_MEM_flush(EX_MEM_flush),
        .pipe_freeze(pipe_freeze), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic             pc, ifid, ifid_fl, idex_fl, exmem_fl, frz, err;
        logic [CNT_W-1:0] sc, fc;
        logic [1:0]       st;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model: consecutive busy cycles, pending abort, halted, sticky error, counts.
    int nbusy = 0;
    bit abort_m = 0, halt_m = 0, err_m = 0;
    int scnt = 0, fcnt = 0;

    task automatic model_reset();
        nbusy = 0; abort_m = 0; halt_m = 0; err_m = 0; scnt = 0; fcnt = 0;
    endtask

    task automatic rst_cycle();
        exp_t e;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        model_reset();
        e = '0;
        e.ifid_fl = 1'b1; e.idex_fl = 1'b1; e.exmem_fl = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic [4:0] exrt, input logic mrd, input logic br,
                        input logic req, input logic rdy, input logic eclr, input logic cclr);
        exp_t e;
        bit busy, lu, inc_s, inc_f;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        IF_ID_rs = rs; IF_ID_rt = rt; ID_uses_rt = urt; ID_EX_rt = exrt;
        ID_EX_memread = mrd; EX_MEM_branch_taken = br;
        dmem_req = req; dmem_ready = rdy; err_clr = eclr; cnt_clr = cclr;

        busy = req && !rdy;
        lu   = mrd && exrt != 0 && (exrt == rs || (urt && exrt == rt));
        e = '0;
        e.pc = 1'b1; e.ifid = 1'b1;
        e.err = err_m;
        e.sc  = CNT_W'(scnt);
        e.fc  = CNT_W'(fcnt);
        e.st  = halt_m ? 2'd3 : abort_m ? 2'd2 : (nbusy > 0) ? 2'd1 : 2'd0;
        inc_s = 0; inc_f = 0;
        if (halt_m) begin
            e.pc = 1'b0; e.ifid = 1'b0; e.frz = 1'b1;
            if (eclr) begin halt_m = 0; err_m = 0; end
        end else if (abort_m) begin
            e.pc = 1'b0; e.ifid = 1'b0;
            e.ifid_fl = 1'b1; e.idex_fl = 1'b1; e.exmem_fl = 1'b1;
            err_m = 1; abort_m = 0; halt_m = 1; inc_s = 1;
        end else if (busy) begin
            e.frz = 1'b1; e.pc = 1'b0; e.ifid = 1'b0; inc_s = 1;
            nbusy++;
            if (nbusy == TIMEOUT) begin abort_m = 1; nbusy = 0; end
        end else begin
            nbusy = 0;
            if (br) begin
                e.ifid_fl = 1'b1; e.idex_fl = 1'b1; e.exmem_fl = 1'b1; inc_f = 1;
            end else if (lu) begin
                e.pc = 1'b0; e.ifid = 1'b0; e.idex_fl = 1'b1; inc_s = 1;
            end
        end
        if (cclr) begin
            scnt = 0; fcnt = 0;
        end else begin
            scnt = (scnt + (inc_s ? 1 : 0)) % CMOD;
            fcnt = (fcnt + (inc_f ? 1 : 0)) % CMOD;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every cycle the DUT presents a full output vector, compared on the falling edge.
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_flush,
                     pipe_freeze, mem_err, stall_cnt, flush_cnt, state_o};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d got pc=%b ifid=%b fl=%b%b%b frz=%b err=%b sc=%0d fc=%0d st=%0d want pc=%b ifid=%b fl=%b%b%b frz=%b err=%b sc=%0d fc=%0d st=%0d",
                             cyc, a.pc, a.ifid, a.ifid_fl, a.idex_fl, a.exmem_fl, a.frz, a.err, a.sc, a.fc, a.st,
                             e.pc, e.ifid, e.ifid_fl, e.idex_fl, e.exmem_fl, e.frz, e.err, e.sc, e.fc, e.st);
                end
            end
        end
    end

    initial begin
        bit slow;
        int wait_n;
        rst_cycle();
        idle(2);
        // Load-use on rs, then the bubbled instruction; r0 destination never stalls.
        step(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(5'd8, 5'd0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // rt match only matters when ID reads rt.
        step(5'd1, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(5'd1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Branch overrides load-use.
        step(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Five-cycle memory wait with a branch held, released on the ready cycle.
        for (int i = 0; i < 5; i++) step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        // err_clr outside HALT is ignored, then timeout into ABORT and HALT.
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < TIMEOUT + 4; i++) step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1);
        // Counter wrap with 17 stalls, then a clear coinciding with a stall.
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) step(5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        // Reset in the middle of a memory wait.
        for (int i = 0; i < 3; i++) step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_cycle();
        idle(2);

        slow = 0;
        for (int n = 0; n < 4000; n++) begin
            if (n % 250 == 0) slow = ~slow;
            if ($urandom_range(0, 399) == 0) rst_cycle();
            else step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                      slow ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0),
                      slow ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 1) == 1),
                      ($urandom_range(0, 15) == 0), ($urandom_range(0, 39) == 0));
        end

        wait_n = 0;
        while (exp_q.size() > 0 && wait_n < 20) begin
            @(negedge clk_i);
            wait_n++;
        end
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage pipelined CPU; sits beside the forwarding logic.
- Handles the hazards forwarding cannot resolve:
  - load-use stalls;
  - taken-branch flushes (branch resolved in MEM);
  - freezes for a variable-latency data memory, with a timeout that aborts and halts the pipe.
- Keeps stall and flush performance counters.

Parameters:
TIMEOUT, 16, max consecutive frozen cycles waiting for dmem_ready before abort (>=2)
CNT_W, 16, width of the performance counters

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
IF_ID_rs  in  5  rs of the instruction in ID
IF_ID_rt  in  5  rt of the instruction in ID
ID_uses_rt  in  1  the instruction in ID reads rt as a source
ID_EX_rt  in  5  destination of the instruction in EX
ID_EX_memread  in  1  the instruction in EX is a load
EX_MEM_branch_taken  in  1  the branch in MEM is taken
dmem_req  in  1  MEM stage is accessing data memory this cycle
dmem_ready  in  1  data memory completes the access this cycle
err_clr  in  1  leave HALT, clear mem_err
cnt_clr  in  1  clear both counters
PC_write  out  1  PC load enable
IF_ID_write  out  1  IF/ID register load enable
IF_ID_flush  out  1  zero IF/ID
ID_EX_flush  out  1  zero ID/EX control bits (bubble)
EX_MEM_flush  out  1  zero EX/MEM control bits
pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB
mem_err  out  1  sticky memory-timeout flag
stall_cnt  out  CNT_W  cycles with PC_write=0 (excluding HALT)
flush_cnt  out  CNT_W  branch flushes applied
state_o  out  2  RUN=00, MEM_WAIT=01, ABORT=10, HALT=11

Behaviour:
- Reset (rst_i=0, asynchronous):
  - Registers: state=RUN, wait_cnt=0, mem_err=0, counters=0.
  - Outputs are forced regardless of state: PC_write=0, IF_ID_write=0, all three flushes=1, pipe_freeze=0.
- Definitions:
  - busy = dmem_req & ~dmem_ready.
  - lu = ID_EX_memread & (ID_EX_rt!=0) & ((ID_EX_rt==IF_ID_rs) | (ID_uses_rt & ID_EX_rt==IF_ID_rt)).
- Default outputs: PC_write=1, IF_ID_write=1, flushes=0, freeze=0.
- RUN / MEM_WAIT decisions are combinational (Mealy), in priority order:
  1. busy: pipe_freeze=1, PC_write=0, IF_ID_write=0, flushes=0.
     - From RUN: next state MEM_WAIT, wait_cnt<=1.
     - In MEM_WAIT: wait_cnt<=wait_cnt+1.
     - If wait_cnt==TIMEOUT-1 in MEM_WAIT: next state ABORT.
  2. else EX_MEM_branch_taken: IF_ID_flush=ID_EX_flush=EX_MEM_flush=1, PC_write=1; flush_cnt+1. Overrides lu.
  3. else lu: PC_write=0, IF_ID_write=0, ID_EX_flush=1. Exactly one cycle, because the bubble clears ID_EX_memread.
- MEM_WAIT exit: when busy=0, return to RUN next edge with wait_cnt=0. Rules 2/3 apply in that same cycle.
- A branch held in EX/MEM during a freeze is applied on the release cycle; it is not lost.
- ABORT (one cycle):
  - pipe_freeze=0, PC_write=0, IF_ID_write=0, all flushes=1.
  - mem_err<=1; next state HALT.
- HALT:
  - PC_write=0, IF_ID_write=0, pipe_freeze=1, flushes=0.
  - Exit to RUN on the edge where err_clr=1, which also clears mem_err.
  - err_clr outside HALT is ignored.
- Counters:
  - stall_cnt +1 on each edge where PC_write=0 in RUN, MEM_WAIT or ABORT.
  - Both counters wrap modulo 2^CNT_W.
  - cnt_clr wins over a simultaneous increment (result 0).
- Reset mid-freeze returns to RUN immediately and discards wait_cnt.

Test Plan:
- Load-use: ID_EX_memread=1, ID_EX_rt=8, IF_ID_rs=8 for 1 cycle -> PC_write=0, IF_ID_write=0, ID_EX_flush=1 for exactly 1 cycle; stall_cnt=1. Same case with ID_EX_rt=0 -> no stall.
- rt check: ID_EX_rt=9, IF_ID_rt=9, ID_uses_rt=0 -> no stall; ID_uses_rt=1 -> 1-cycle stall.
- Branch priority: EX_MEM_branch_taken=1 together with the load-use condition -> all three flushes=1, PC_write=1, no stall; flush_cnt=1.
- Memory wait: dmem_req=1, dmem_ready low for 5 cycles -> pipe_freeze=1 for 5 cycles, state_o=01 from cycle 2, stall_cnt=5. With branch_taken held, flushes fire on the ready cycle.
- Timeout (TIMEOUT=16): dmem_ready never rises -> 16 frozen cycles, then 1 ABORT cycle (flushes=1), then state_o=11, mem_err=1. err_clr -> RUN, mem_err=0.
- Wrap/clear (CNT_W=4): 17 stalls -> stall_cnt=1. cnt_clr asserted with a stall -> stall_cnt=0. rst_i low mid-MEM_WAIT -> state_o=00, counters 0.
